axis_bus_1_4_demux: RTL and testbench

- Packet-atomic 1-to-4 AXI-Stream router on the TX side.
- Takes one 32-bit AXIS stream from the input FIFO master port and delivers each whole frame to one of four frame-encoder slave buses, chosen by bus_sel.
- Route is locked at the first beat of a frame and held until its tlast beat is accepted.
- Single registered output stage gives full tready backpressure per channel.

---
 rtl/axis_route_pkg.sv | 33 +++
 rtl/axis_bus_1_4_demux_if.sv | 11 +
 rtl/axis_slot_reg.sv | 35 +++
 rtl/axis_bus_1_4_demux.sv | 137 +++++++++++++
 tb/tb_axis_bus_1_4_demux.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_route_pkg.sv
// Shared routing codes, FSM state and beat type for the AXIS bus mux/demux pair.
package axis_route_pkg;

  localparam logic [3:0] CHOOSE_FIFO_0   = 4'b0100;
  localparam logic [3:0] CHOOSE_FIFO_1   = 4'b0101;
  localparam logic [3:0] CHOOSE_FIFO_2   = 4'b0110;
  localparam logic [3:0] CHOOSE_FIFO_3   = 4'b0111;
  localparam logic [3:0] NON_FIFO_CHOOSE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
  } beat_t;

  // Returns {valid, index}; any code outside the CHOOSE set is invalid.
  function automatic logic [2:0] sel_decode(input logic [3:0] sel);
    case (sel)
      CHOOSE_FIFO_0: return {1'b1, 2'd0};
      CHOOSE_FIFO_1: return {1'b1, 2'd1};
      CHOOSE_FIFO_2: return {1'b1, 2'd2};
      CHOOSE_FIFO_3: return {1'b1, 2'd3};
      default:       return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/axis_bus_1_4_demux_if.sv
// 32-bit AXI-Stream bus bundle with master/slave views.
interface axis_bus_1_4_demux_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_slot_reg.sv
// One-entry register slice: load wins over drain, payload is not reset.
module axis_slot_reg
  import axis_route_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  drain_i,
  input  beat_t beat_i,
  output logic  valid_o,
  output beat_t beat_o
);

  logic  valid_q, valid_d;
  beat_t beat_q;

  always_comb begin
    valid_d = valid_q;
    if (load_i)       valid_d = 1'b1;
    else if (drain_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (load_i) beat_q <= beat_i;
  end

  assign valid_o = valid_q;
  assign beat_o  = beat_q;

endmodule

// File: rtl/axis_bus_1_4_demux.sv
// Packet-atomic 1-to-4 AXIS router; route locks on the first beat of each frame.
// Optional AXIS_DEMUX_DROP_INVALID_EN: discard frames with an invalid bus_sel and count them.
module axis_bus_1_4_demux
  import axis_route_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  bus_sel,
  axis_bus_1_4_demux_if.slave         axis_in,
  axis_bus_1_4_demux_if.master        axis_out_0,
  axis_bus_1_4_demux_if.master        axis_out_1,
  axis_bus_1_4_demux_if.master        axis_out_2,
  axis_bus_1_4_demux_if.master        axis_out_3,
  output logic                        busy,
  output logic [1:0]                  route
`ifdef AXIS_DEMUX_DROP_INVALID_EN
  , output logic [15:0]               drop_cnt
`endif
);

  state_t     state_q, state_d;
  logic [1:0] route_q, route_d;
  logic       busy_q, busy_d;
  logic       sel_ok;
  logic [1:0] sel_idx;
  logic       in_ready, load, drain, slot_free, slot_valid;
  logic [3:0] out_ready, out_sel;
  beat_t      in_beat, slot_beat;

  assign {sel_ok, sel_idx} = sel_decode(bus_sel);
  assign in_beat   = {axis_in.tdata, axis_in.tkeep, axis_in.tlast};
  assign out_ready = {axis_out_3.tready, axis_out_2.tready, axis_out_1.tready, axis_out_0.tready};
  assign drain     = slot_valid && out_ready[route_q];
  assign slot_free = !slot_valid || out_ready[route_q];

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    busy_d   = busy_q;
    in_ready = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = slot_free && sel_ok;
        busy_d   = 1'b0;
        if (axis_in.tvalid && in_ready) begin
          route_d = sel_idx;
          load    = 1'b1;
          busy_d  = 1'b1;
          if (!axis_in.tlast) state_d = BUSY;
        end
`ifdef AXIS_DEMUX_DROP_INVALID_EN
        else if (axis_in.tvalid && !sel_ok) begin
          state_d = DROP;
        end
`endif
      end
      BUSY: begin
        in_ready = slot_free;
        if (axis_in.tvalid && in_ready) begin
          load = 1'b1;
          if (axis_in.tlast) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
`ifdef AXIS_DEMUX_DROP_INVALID_EN
      DROP: begin
        in_ready = 1'b1;
        if (axis_in.tvalid && axis_in.tlast) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AXIS_DEMUX_DROP_INVALID_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt_q <= 16'd0;
    else if (state_q == DROP && axis_in.tvalid && axis_in.tlast && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif

  axis_slot_reg u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .drain_i (drain),
    .beat_i  (in_beat),
    .valid_o (slot_valid),
    .beat_o  (slot_beat)
  );

  // Non-selected outputs are forced to zero, so payload never leaks across channels.
  always_comb begin
    for (int n = 0; n < 4; n++) out_sel[n] = slot_valid && (route_q == 2'(n));
  end

  assign axis_out_0.tvalid = out_sel[0];
  assign axis_out_0.tdata  = out_sel[0] ? slot_beat.tdata : 32'd0;
  assign axis_out_0.tkeep  = out_sel[0] ? slot_beat.tkeep : 4'd0;
  assign axis_out_0.tlast  = out_sel[0] && slot_beat.tlast;
  assign axis_out_1.tvalid = out_sel[1];
  assign axis_out_1.tdata  = out_sel[1] ? slot_beat.tdata : 32'd0;
  assign axis_out_1.tkeep  = out_sel[1] ? slot_beat.tkeep : 4'd0;
  assign axis_out_1.tlast  = out_sel[1] && slot_beat.tlast;
  assign axis_out_2.tvalid = out_sel[2];
  assign axis_out_2.tdata  = out_sel[2] ? slot_beat.tdata : 32'd0;
  assign axis_out_2.tkeep  = out_sel[2] ? slot_beat.tkeep : 4'd0;
  assign axis_out_2.tlast  = out_sel[2] && slot_beat.tlast;
  assign axis_out_3.tvalid = out_sel[3];
  assign axis_out_3.tdata  = out_sel[3] ? slot_beat.tdata : 32'd0;
  assign axis_out_3.tkeep  = out_sel[3] ? slot_beat.tkeep : 4'd0;
  assign axis_out_3.tlast  = out_sel[3] && slot_beat.tlast;

  assign axis_in.tready = rst_n && in_ready;
  assign busy           = busy_q;
  assign route          = route_q;

endmodule

// File: tb/tb_axis_bus_1_4_demux.sv
// Directed bench for axis_bus_1_4_demux (default build; AXIS_DEMUX_DROP_INVALID_EN adds a drop test).
module tb_axis_bus_1_4_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bus_sel = 4'd0;
  logic       busy;
  logic [1:0] route;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef AXIS_DEMUX_DROP_INVALID_EN
  logic [15:0] drop_cnt;
`endif

  axis_bus_1_4_demux_if in_if ();
  axis_bus_1_4_demux_if o0 ();
  axis_bus_1_4_demux_if o1 ();
  axis_bus_1_4_demux_if o2 ();
  axis_bus_1_4_demux_if o3 ();

  always #5 clk = ~clk;

  axis_bus_1_4_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_sel    (bus_sel),
    .axis_in    (in_if),
    .axis_out_0 (o0),
    .axis_out_1 (o1),
    .axis_out_2 (o2),
    .axis_out_3 (o3),
    .busy       (busy),
    .route      (route)
`ifdef AXIS_DEMUX_DROP_INVALID_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    in_if.tvalid = v;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, in_if.tready}, {31'd0, exp});
  endtask

  // idx < 0 means no output may be active; inactive outputs must carry zero payload.
  task automatic exp_out(input string tag, input int idx, input logic [31:0] d,
                         input logic [3:0] k, input logic l);
    chk({tag, "/vld"}, {28'd0, o3.tvalid, o2.tvalid, o1.tvalid, o0.tvalid},
        (idx < 0) ? 32'd0 : (32'd1 << idx));
    chk({tag, "/data"}, o0.tdata | o1.tdata | o2.tdata | o3.tdata, (idx < 0) ? 32'd0 : d);
    chk({tag, "/keep"}, {28'd0, o0.tkeep | o1.tkeep | o2.tkeep | o3.tkeep},
        (idx < 0) ? 32'd0 : {28'd0, k});
    chk({tag, "/last"}, {31'd0, o0.tlast | o1.tlast | o2.tlast | o3.tlast},
        (idx < 0) ? 32'd0 : {31'd0, l});
  endtask

  initial begin
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    o0.tready = 1'b1; o1.tready = 1'b1; o2.tready = 1'b1; o3.tready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk_rdy("rst_rdy", 1'b0);
    exp_out("rst", -1, 32'd0, 4'd0, 1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_route", {30'd0, route}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 4-beat frame to output 2
    bus_sel = 4'b0110;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 32'(k) * 32'h11111111, 4'hF, (k == 4));
      chk_rdy("t1_rdy", 1'b1);
      tick();
      exp_out("t1_beat", 2, 32'(k) * 32'h11111111, 4'hF, (k == 4));
      if (k == 1) begin
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_route", {30'd0, route}, 32'd2);
      end
    end
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    tick();
    exp_out("t1_drain", -1, 32'd0, 4'd0, 1'b0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_route_hold", {30'd0, route}, 32'd2);

    // bus_sel change mid-frame is ignored; next frame uses the new code
    bus_sel = 4'b0101;
    drive(1'b1, 32'hA0000001, 4'h3, 1'b0); chk_rdy("t2_rdy1", 1'b1); tick();
    exp_out("t2_b1", 1, 32'hA0000001, 4'h3, 1'b0);
    drive(1'b1, 32'hA0000002, 4'hF, 1'b0); chk_rdy("t2_rdy2", 1'b1); tick();
    exp_out("t2_b2", 1, 32'hA0000002, 4'hF, 1'b0);
    bus_sel = 4'b0100;
    drive(1'b1, 32'hA0000003, 4'h1, 1'b1); chk_rdy("t2_rdy3", 1'b1); tick();
    exp_out("t2_b3", 1, 32'hA0000003, 4'h1, 1'b1);
    chk("t2_route", {30'd0, route}, 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();
    drive(1'b1, 32'hB0B0B0B0, 4'hF, 1'b1); chk_rdy("t2_rdy4", 1'b1); tick();
    exp_out("t2_next", 0, 32'hB0B0B0B0, 4'hF, 1'b1);
    chk("t2_route_next", {30'd0, route}, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();

    // Backpressure on output 3
    bus_sel = 4'b0111;
    drive(1'b1, 32'hC0000001, 4'hF, 1'b0); chk_rdy("t3_rdy1", 1'b1); tick();
    exp_out("t3_b1", 3, 32'hC0000001, 4'hF, 1'b0);
    drive(1'b1, 32'hC0000002, 4'hF, 1'b0); chk_rdy("t3_rdy2", 1'b1); tick();
    exp_out("t3_b2", 3, 32'hC0000002, 4'hF, 1'b0);
    o3.tready = 1'b0;
    drive(1'b1, 32'hC0000003, 4'hF, 1'b1); chk_rdy("t3_stall1", 1'b0); tick();
    exp_out("t3_hold1", 3, 32'hC0000002, 4'hF, 1'b0);
    chk_rdy("t3_stall2", 1'b0); tick();
    exp_out("t3_hold2", 3, 32'hC0000002, 4'hF, 1'b0);
    o3.tready = 1'b1;
    chk_rdy("t3_resume", 1'b1); tick();
    exp_out("t3_b3", 3, 32'hC0000003, 4'hF, 1'b1);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();
    exp_out("t3_drain", -1, 32'd0, 4'd0, 1'b0);

`ifndef AXIS_DEMUX_DROP_INVALID_EN
    // Invalid selection stalls until a valid code appears
    bus_sel = 4'b0000;
    drive(1'b1, 32'hD0D0D0D0, 4'h7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk_rdy("t4_stall", 1'b0); tick();
      exp_out("t4_none", -1, 32'd0, 4'd0, 1'b0);
    end
    bus_sel = 4'b0101;
    chk_rdy("t4_go", 1'b1); tick();
    exp_out("t4_out", 1, 32'hD0D0D0D0, 4'h7, 1'b1);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();
    chk("t4_busy_end", {31'd0, busy}, 32'd0);
`endif

    // Back-to-back single-beat frames
    bus_sel = 4'b0100;
    drive(1'b1, 32'h0000AAAA, 4'hF, 1'b1); chk_rdy("t5_rdyA", 1'b1); tick();
    exp_out("t5_A", 0, 32'h0000AAAA, 4'hF, 1'b1);
    chk("t5_busyA", {31'd0, busy}, 32'd1);
    bus_sel = 4'b0111;
    drive(1'b1, 32'h0000BBBB, 4'hC, 1'b1); chk_rdy("t5_rdyB", 1'b1); tick();
    exp_out("t5_B", 3, 32'h0000BBBB, 4'hC, 1'b1);
    chk("t5_routeB", {30'd0, route}, 32'd3);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();
    chk("t5_busy_end", {31'd0, busy}, 32'd0);
    exp_out("t5_drain", -1, 32'd0, 4'd0, 1'b0);

    // Reset mid-frame, then a clean frame
    bus_sel = 4'b0110;
    drive(1'b1, 32'hE0000001, 4'hF, 1'b0); tick();
    drive(1'b1, 32'hE0000002, 4'hF, 1'b0); tick();
    exp_out("t6_b2", 2, 32'hE0000002, 4'hF, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 32'hE0000003, 4'hF, 1'b0);
    chk_rdy("t6_rst_rdy", 1'b0); tick();
    exp_out("t6_rst", -1, 32'd0, 4'd0, 1'b0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_route", {30'd0, route}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    bus_sel = 4'b0101;
    tick();
    drive(1'b1, 32'hF0000001, 4'hF, 1'b0); chk_rdy("t6_rdy1", 1'b1); tick();
    exp_out("t6_f1", 1, 32'hF0000001, 4'hF, 1'b0);
    drive(1'b1, 32'hF0000002, 4'h8, 1'b1); chk_rdy("t6_rdy2", 1'b1); tick();
    exp_out("t6_f2", 1, 32'hF0000002, 4'h8, 1'b1);
    chk("t6_route_new", {30'd0, route}, 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0); tick();

`ifdef AXIS_DEMUX_DROP_INVALID_EN
    // Invalid selection: frame is swallowed and counted
    bus_sel = 4'b0000;
    drive(1'b1, 32'h60000001, 4'hF, 1'b0); chk_rdy("td_idle", 1'b0); tick();
    chk_rdy("td_rdy1", 1'b1); tick();
    exp_out("td_b1", -1, 32'd0, 4'd0, 1'b0);
    drive(1'b1, 32'h60000002, 4'hF, 1'b0); chk_rdy("td_rdy2", 1'b1); tick();
    exp_out("td_b2", -1, 32'd0, 4'd0, 1'b0);
    drive(1'b1, 32'h60000003, 4'hF, 1'b1); chk_rdy("td_rdy3", 1'b1); tick();
    exp_out("td_b3", -1, 32'd0, 4'd0, 1'b0);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    chk("td_cnt", {16'd0, drop_cnt}, 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
